// File: rtl/rtc_ssd_core.sv
// rtc_ssd_core: 24-hour HH:MM:SS clock kept in BCD, a one-shot load port and a
// multiplexed active-low seven-segment display driver with a blinking colon.
//
// state   | meaning
// ST_RUN  | time counting, load port ready
// ST_LOAD | apply (or reject) the load values captured in ST_RUN, one cycle
module rtc_ssd_core #(
  parameter int CLK_HZ   = 100000000,
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                set_valid,
  output logic                set_ready,
  input  logic [4:0]          set_hh,
  input  logic [5:0]          set_mm,
  input  logic [5:0]          set_ss,
  output logic                set_err,
  output logic                sec_tick,
  output logic [N_DIGITS-1:0] basys_anode,
  output logic [6:0]          display_ssd,
  output logic                display_dp
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  state_t      r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_scan_cnt;
  logic [2:0]  r_idx;
  logic        r_mode;
  logic [4:0]  r_ld_hh;
  logic [5:0]  r_ld_mm, r_ld_ss;
  logic [3:0]  r_s1, r_s10, r_m1, r_m10, r_h1, r_h10;
  logic        w_tc, w_fields_ok, w_load_ok, w_load_bad;
  logic        w_c_s1, w_c_s10, w_c_m1, w_c_m10, w_c_h1, w_c_day;
  logic [3:0]  w_digit;
  logic [6:0]  w_seg;
  logic [N_DIGITS-1:0] w_anode_nxt;
  logic        w_dp_nxt;

  assign w_tc        = (r_presc == PW'(CLK_HZ - 1));
  assign w_fields_ok = (r_ld_hh <= 5'd23) && (r_ld_mm <= 6'd59) && (r_ld_ss <= 6'd59);

  // Carry chain: a single tick can roll 23:59:59 over to 00:00:00.
  assign w_c_s1  = (r_s1 == 4'd9);
  assign w_c_s10 = w_c_s1 && (r_s10 == 4'd5);
  assign w_c_m1  = w_c_s10 && (r_m1 == 4'd9);
  assign w_c_m10 = w_c_m1 && (r_m10 == 4'd5);
  assign w_c_h1  = w_c_m10 && (r_h1 == 4'd9);
  assign w_c_day = w_c_m10 && (r_h10 == 4'd2) && (r_h1 == 4'd3);

  // FSM state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    set_ready   = 1'b0;
    w_load_ok   = 1'b0;
    w_load_bad  = 1'b0;
    case (r_state)
      ST_RUN: begin
        set_ready = 1'b1;
        if (set_valid) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_state_nxt = ST_RUN;
        w_load_ok   = w_fields_ok;
        w_load_bad  = !w_fields_ok;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign set_err = w_load_bad;

  // Capture load values when the request is accepted
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ld_hh <= '0;
      r_ld_mm <= '0;
      r_ld_ss <= '0;
    end else if (r_state == ST_RUN && set_valid) begin
      r_ld_hh <= set_hh;
      r_ld_mm <= set_mm;
      r_ld_ss <= set_ss;
    end

  // Prescaler and tick; a valid load restarts the second and eats a coincident tick
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_presc  <= '0;
      sec_tick <= 1'b0;
    end else begin
      r_presc  <= (w_load_ok || w_tc) ? '0 : r_presc + PW'(1);
      sec_tick <= w_tc && !w_load_ok;
    end

  // BCD time: load wins over increment
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {r_h10, r_h1, r_m10, r_m1, r_s10, r_s1} <= '0;
    end else if (w_load_ok) begin
      r_h10 <= 4'(r_ld_hh / 5'd10);
      r_h1  <= 4'(r_ld_hh % 5'd10);
      r_m10 <= 4'(r_ld_mm / 6'd10);
      r_m1  <= 4'(r_ld_mm % 6'd10);
      r_s10 <= 4'(r_ld_ss / 6'd10);
      r_s1  <= 4'(r_ld_ss % 6'd10);
    end else if (w_tc) begin
      r_s1 <= w_c_s1 ? 4'd0 : r_s1 + 4'd1;
      if (w_c_s1)  r_s10 <= w_c_s10 ? 4'd0 : r_s10 + 4'd1;
      if (w_c_s10) r_m1  <= w_c_m1 ? 4'd0 : r_m1 + 4'd1;
      if (w_c_m1)  r_m10 <= w_c_m10 ? 4'd0 : r_m10 + 4'd1;
      if (w_c_m10) begin
        r_h1  <= (w_c_day || w_c_h1) ? 4'd0 : r_h1 + 4'd1;
        r_h10 <= w_c_day ? 4'd0 : (w_c_h1 ? r_h10 + 4'd1 : r_h10);
      end
    end

  // Scan slot counter and digit index; mode is only resampled, never resets the scan
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_mode     <= 1'b0;
    end else begin
      r_mode <= mode;
      if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == 3'(N_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end
    end

  // Digit selection for the current index
  always_comb begin
    w_digit = 4'hf;
    if (N_DIGITS == 6 || r_mode) begin
      case (r_idx)
        3'd0: w_digit = r_s1;
        3'd1: w_digit = r_s10;
        3'd2: w_digit = r_m1;
        3'd3: w_digit = r_m10;
        3'd4: w_digit = (N_DIGITS == 6) ? r_h1 : 4'hf;
        3'd5: w_digit = (N_DIGITS == 6) ? r_h10 : 4'hf;
        default: w_digit = 4'hf;
      endcase
    end else begin
      case (r_idx)
        3'd0: w_digit = r_m1;
        3'd1: w_digit = r_m10;
        3'd2: w_digit = r_h1;
        3'd3: w_digit = r_h10;
        default: w_digit = 4'hf;
      endcase
    end
  end

  // Seven-segment decode {g,f,e,d,c,b,a}, active-low; non-decimal values blank
  always_comb begin
    case (w_digit)
      4'd0: w_seg = 7'b1000000;
      4'd1: w_seg = 7'b1111001;
      4'd2: w_seg = 7'b0100100;
      4'd3: w_seg = 7'b0110000;
      4'd4: w_seg = 7'b0011001;
      4'd5: w_seg = 7'b0010010;
      4'd6: w_seg = 7'b0000010;
      4'd7: w_seg = 7'b1111000;
      4'd8: w_seg = 7'b0000000;
      4'd9: w_seg = 7'b0010000;
      default: w_seg = 7'b1111111;
    endcase
  end

  // Anode pattern: all off in the first cycle of a slot to avoid ghosting
  always_comb begin
    w_anode_nxt = '1;
    for (int i = 0; i < N_DIGITS; i++)
      w_anode_nxt[i] = !((r_scan_cnt != '0) && (r_idx == 3'(i)));
  end

  assign w_dp_nxt = !(((r_idx == 3'd2) || (N_DIGITS == 6 && r_idx == 3'd4)) &&
                      (r_presc < PW'(CLK_HZ / 2)));

  // Registered display outputs, all aligned to the same scan cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      basys_anode <= '1;
      display_ssd <= 7'h7f;
      display_dp  <= 1'b1;
    end else begin
      basys_anode <= w_anode_nxt;
      display_ssd <= w_seg;
      display_dp  <= w_dp_nxt;
    end

endmodule
